uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter READ_LAT, default 2, is the number of clk cycles from the bus_re pulse to valid bus_rdata (legal range 1-15).
REQ-002 Parameter TIMEOUT_CYC, default 65535, is the maximum number of idle clk cycles allowed between bytes of one command.
REQ-003 clk  in  1  single system clock (25 MHz domain); all logic is rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rx_valid  in  1  one-cycle strobe from the UART receiver; rx_data is valid in that cycle.
REQ-006 rx_data  in  8  received byte.
REQ-007 tx_active  in  1  UART transmitter is busy.
REQ-008 tx_done  in  1  one-cycle strobe when the UART transmitter finishes a byte.
REQ-009 tx_start  out  1  one-cycle request to transmit tx_data.
REQ-010 tx_data  out  8  byte to transmit.
REQ-011 bus_addr  out  16  CPU-space address for the host access.
REQ-012 bus_wdata  out  8  write data.
REQ-013 bus_we  out  1  one-cycle write strobe.
REQ-014 bus_re  out  1  one-cycle read strobe.
REQ-015 bus_rdata  in  8  read data, sampled READ_LAT cycles after bus_re.
REQ-016 cpu_hold  out  1  holds the 6502/PPU in reset and grants the host the memory bus.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 Command bytes: 0x02 = write (addr_hi, addr_lo, data); 0x03 = read (addr_hi, addr_lo, then one byte is returned); 0x06 = set cpu_hold; 0x07 = clear cpu_hold; all other bytes in IDLE are discarded with no side effect.
REQ-019 FSM states: IDLE, ADDR_HI, ADDR_LO, DATA, RD_WAIT, TX_REQ, TX_WAIT.
REQ-020 IDLE: rx_valid with 0x02 or 0x03 latches the opcode -> ADDR_HI; 0x06 or 0x07 updates cpu_hold on the next edge and stays in IDLE.
REQ-021 ADDR_HI: rx_valid latches bus_addr[15:8] -> ADDR_LO.
REQ-022 ADDR_LO: rx_valid latches bus_addr[7:0]; a write goes -> DATA; a read asserts bus_re for exactly one cycle on the following edge -> RD_WAIT.
REQ-023 DATA: rx_valid latches bus_wdata and asserts bus_we for exactly one cycle on the following edge with addr/data stable -> IDLE.
REQ-024 RD_WAIT: counts READ_LAT cycles after the bus_re cycle, then latches bus_rdata into tx_data -> TX_REQ.
REQ-025 TX_REQ: when tx_active is low, pulse tx_start for one cycle -> TX_WAIT; otherwise wait.
REQ-026 TX_WAIT: tx_done -> IDLE; tx_data is held constant from TX_REQ until IDLE.
REQ-027 Write latency: bus_we is high in the cycle after the data byte's rx_valid.
REQ-028 Read latency: bus_re is high in the cycle after the addr_lo byte's rx_valid; tx_start occurs READ_LAT+1 cycles later if tx_active is low.
REQ-029 rx_valid received in RD_WAIT, TX_REQ or TX_WAIT is dropped; the command is not aborted.
REQ-030 Inter-byte timeout: in ADDR_HI, ADDR_LO or DATA, a 16-bit counter clears on each rx_valid; reaching TIMEOUT_CYC -> IDLE with no bus strobe.
REQ-031 bus_we and bus_re are never high in the same cycle and never high outside the cycles defined above.
REQ-032 Addresses pass through unmodified across the full 0x0000-0xFFFF range; no wrap, mirroring or decoding is performed here.
REQ-033 cpu_hold does not gate bus strobes; the host may access the bus in either cpu_hold state.
REQ-034 Commands 0x06 or 0x07 received as an address or data byte are treated as data only.

Reset
REQ-035 While rst is high: state = IDLE; tx_start, bus_we, bus_re, busy = 0; bus_addr, bus_wdata, tx_data = 0; cpu_hold = 0; timeout and latency counters = 0.
REQ-036 Reset asserted mid-command aborts the command immediately, with no strobe issued after rst rises.
REQ-037 After rst falls, the first rx_valid is decoded as a command byte.

Verification
REQ-038 Bytes 02,80,10,A5 -> one bus_we pulse with bus_addr=0x8010 and bus_wdata=0xA5 in the cycle after the A5 strobe; busy falls in the same cycle.
REQ-039 Bytes 03,20,07 with bus_rdata=0x3C, READ_LAT=2 -> bus_re pulse at addr 0x2007, then tx_start with tx_data=0x3C 3 cycles later; IDLE after tx_done.
REQ-040 Byte 06 -> cpu_hold=1; byte 07 -> cpu_hold=0; byte 55 in IDLE -> no state change and no strobes.
REQ-041 Bytes 02,12 then silence for TIMEOUT_CYC cycles -> return to IDLE with no bus_we; next bytes 06 -> cpu_hold=1.
REQ-042 Read with tx_active held high for 50 cycles -> tx_start is delayed until tx_active falls; extra rx bytes sent during this period are ignored.
REQ-043 Assert rst one cycle after the addr_lo byte of a read -> no bus_re, all outputs at reset values, and a following 02,00,00,FF write completes normally.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// Host memory-bus port of the UART command decoder: the decoder drives address,
// write data and strobes; the memory side returns read data.
interface uart_cmd_decoder_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes host commands arriving byte-wise over a UART into single-byte memory
// bus writes and reads, returns read data over the UART and controls cpu_hold.
module uart_cmd_decoder #(
  parameter int READ_LAT    = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  uart_cmd_decoder_if.master         bus,
  output logic                       cpu_hold,
  output logic                       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_TX_REQ  = 3'd5;
  localparam logic [2:0] S_TX_WAIT = 3'd6;

  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_HOLD_SET = 8'h06;
  localparam logic [7:0] OP_HOLD_CLR = 8'h07;

  localparam logic [3:0]  LAT_LAST = 4'(READ_LAT);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC);

  logic [2:0]  state;
  logic        is_read;
  logic [3:0]  lat_cnt;
  logic [15:0] tmo_cnt;
  logic        collecting;
  logic        tmo_hit;

  assign collecting = (state == S_ADDR_HI) || (state == S_ADDR_LO) || (state == S_DATA);
  assign tmo_hit    = !rx_valid && (tmo_cnt == TMO_LAST);
  assign busy       = (state != S_IDLE);
  // Combinational so the request lands READ_LAT+1 cycles after bus_re when the transmitter is free.
  assign tx_start   = (state == S_TX_REQ) && !tx_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      is_read       <= 1'b0;
      lat_cnt       <= 4'd0;
      tmo_cnt       <= 16'd0;
      cpu_hold      <= 1'b0;
      tx_data       <= 8'd0;
      bus.bus_addr  <= 16'd0;
      bus.bus_wdata <= 8'd0;
      bus.bus_we    <= 1'b0;
      bus.bus_re    <= 1'b0;
    end else begin
      bus.bus_we <= 1'b0;
      bus.bus_re <= 1'b0;

      if (!collecting || rx_valid)
        tmo_cnt <= 16'd0;
      else if (tmo_cnt != TMO_LAST)
        tmo_cnt <= tmo_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              OP_WRITE: begin
                is_read <= 1'b0;
                state   <= S_ADDR_HI;
              end
              OP_READ: begin
                is_read <= 1'b1;
                state   <= S_ADDR_HI;
              end
              OP_HOLD_SET: cpu_hold <= 1'b1;
              OP_HOLD_CLR: cpu_hold <= 1'b0;
              default: ;
            endcase
          end
        end
        S_ADDR_HI: begin
          if (rx_valid) begin
            bus.bus_addr[15:8] <= rx_data;
            state              <= S_ADDR_LO;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        S_ADDR_LO: begin
          if (rx_valid) begin
            bus.bus_addr[7:0] <= rx_data;
            if (is_read) begin
              bus.bus_re <= 1'b1;
              state      <= S_RD_WAIT;
            end else begin
              state <= S_DATA;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            bus.bus_wdata <= rx_data;
            bus.bus_we    <= 1'b1;
            state         <= S_IDLE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          // lat_cnt is 0 in the bus_re cycle, so it equals READ_LAT when bus_rdata is valid.
          if (lat_cnt == LAT_LAST) begin
            tx_data <= bus.bus_rdata;
            lat_cnt <= 4'd0;
            state   <= S_TX_REQ;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_TX_REQ: begin
          if (!tx_active)
            state <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (tx_done)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a command-level reference model checked
// every cycle, plus literal expectations on key command results.
module tb_uart_cmd_decoder;
  localparam int READ_LAT    = 2;
  localparam int TIMEOUT_CYC = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       tx_active;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       cpu_hold;
  logic       busy;

  logic        ext_busy = 1'b0;
  int          tx_cnt = 0;
  logic [7:0]  rdata_val = 8'd0;
  logic [15:0] rd_pipe = 16'd0;

  int n_chk  = 0;
  int n_fail = 0;

  uart_cmd_decoder_if bus_if ();

  uart_cmd_decoder #(.READ_LAT(READ_LAT), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_active(tx_active),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .bus      (bus_if.master),
    .cpu_hold (cpu_hold),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign tx_active = ext_busy || (tx_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory returns data exactly READ_LAT cycles after bus_re; transmitter takes 4 cycles per byte.
  always @(posedge clk) begin : responder
    logic s_txs;
    logic s_re;
    s_txs = tx_start;
    s_re  = bus_if.bus_re;
    #1;
    rd_pipe = {rd_pipe[14:0], s_re};
    bus_if.bus_rdata = rd_pipe[READ_LAT-1] ? rdata_val : 8'hEE;
    tx_done = 1'b0;
    if (tx_cnt != 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (s_txs) tx_cnt = 4;
  end

  // Reference model: command bytes collected in a queue, read phase tracked by absolute cycle numbers.
  int         cyc = 0;
  logic [7:0] q[$];
  logic       m_hold = 1'b0;
  logic       exp_we = 1'b0;
  logic       exp_re = 1'b0;
  logic       rd_active = 1'b0;
  logic       started = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [7:0] m_wdata = 8'd0;
  logic [7:0] m_txd = 8'd0;
  int         gap = 0;
  int         re_cyc = 0;

  always @(posedge clk) begin : model
    int ended;
    ended = cyc;
    cyc   = cyc + 1;
    exp_we = 1'b0;
    exp_re = 1'b0;
    if (rst) begin
      q.delete();
      m_hold    = 1'b0;
      rd_active = 1'b0;
      started   = 1'b0;
      gap       = 0;
    end else if (rd_active) begin
      if (!started) begin
        if (ended == re_cyc + READ_LAT) m_txd = rdata_val;
        if (ended >= re_cyc + READ_LAT + 1 && !tx_active) started = 1'b1;
      end else if (tx_done) begin
        rd_active = 1'b0;
      end
    end else if (rx_valid) begin
      gap = 0;
      if (q.size() == 0) begin
        if (rx_data == 8'h02 || rx_data == 8'h03) q.push_back(rx_data);
        else if (rx_data == 8'h06) m_hold = 1'b1;
        else if (rx_data == 8'h07) m_hold = 1'b0;
      end else begin
        q.push_back(rx_data);
        if (q.size() == ((q[0] == 8'h03) ? 3 : 4)) begin
          m_addr = {q[1], q[2]};
          if (q[0] == 8'h03) begin
            exp_re    = 1'b1;
            rd_active = 1'b1;
            started   = 1'b0;
            re_cyc    = ended + 1;
          end else begin
            m_wdata = q[3];
            exp_we  = 1'b1;
          end
          q.delete();
        end
      end
    end else if (q.size() != 0) begin
      gap = gap + 1;
      if (gap > TIMEOUT_CYC) q.delete();
    end
  end

  always @(negedge clk) begin : compare
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_we", bus_if.bus_we, 0);
      check("rst_re", bus_if.bus_re, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_addr", bus_if.bus_addr, 0);
      check("rst_wdata", bus_if.bus_wdata, 0);
      check("rst_tx_data", tx_data, 0);
    end else begin
      check("bus_we", bus_if.bus_we, exp_we);
      check("bus_re", bus_if.bus_re, exp_re);
      check("busy", busy, (q.size() != 0) || rd_active);
      check("cpu_hold", cpu_hold, m_hold);
      check("tx_start", tx_start,
            rd_active && !started && (cyc >= re_cyc + READ_LAT + 1) && !tx_active);
      if (exp_we) begin
        check("wr_addr", bus_if.bus_addr, m_addr);
        check("wr_data", bus_if.bus_wdata, m_wdata);
      end
      if (exp_re) check("rd_addr", bus_if.bus_addr, m_addr);
      if (rd_active && (cyc >= re_cyc + READ_LAT + 1)) check("tx_data", tx_data, m_txd);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < max_cyc) begin
      @(negedge clk);
      k = k + 1;
    end
    check("return_to_idle", busy, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic write
    send_byte(8'h02); send_byte(8'h80); send_byte(8'h10); send_byte(8'hA5);
    @(negedge clk);
    check("lit_wr_we", bus_if.bus_we, 1);
    check("lit_wr_addr", bus_if.bus_addr, 16'h8010);
    check("lit_wr_data", bus_if.bus_wdata, 8'hA5);
    check("lit_wr_busy", busy, 0);
    @(negedge clk);
    check("lit_wr_we_single", bus_if.bus_we, 0);

    // Basic read
    rdata_val = 8'h3C;
    send_byte(8'h03); send_byte(8'h20); send_byte(8'h07);
    @(negedge clk);
    check("lit_rd_re", bus_if.bus_re, 1);
    check("lit_rd_addr", bus_if.bus_addr, 16'h2007);
    repeat (3) @(negedge clk);
    check("lit_rd_tx_start", tx_start, 1);
    check("lit_rd_tx_data", tx_data, 8'h3C);
    wait_idle(20);

    // cpu_hold control and unknown opcode
    send_byte(8'h06);
    @(negedge clk);
    check("lit_hold_set", cpu_hold, 1);
    send_byte(8'h55);
    @(negedge clk);
    check("lit_junk_hold", cpu_hold, 1);
    check("lit_junk_busy", busy, 0);
    send_byte(8'h07);
    @(negedge clk);
    check("lit_hold_clr", cpu_hold, 0);

    // Hold opcodes inside a command are plain data
    send_byte(8'h06);
    send_byte(8'h02); send_byte(8'h06); send_byte(8'h07); send_byte(8'h06);
    @(negedge clk);
    check("lit_data06_addr", bus_if.bus_addr, 16'h0607);
    check("lit_data06_wdata", bus_if.bus_wdata, 8'h06);
    check("lit_data06_hold", cpu_hold, 1);
    send_byte(8'h07);

    // Address range extremes
    rdata_val = 8'hC3;
    send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF);
    @(negedge clk);
    check("lit_rd_ffff", bus_if.bus_addr, 16'hFFFF);
    wait_idle(20);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);

    // Inter-byte timeout
    send_byte(8'h02); send_byte(8'h12);
    repeat (TIMEOUT_CYC + 1) @(negedge clk);
    check("lit_tmo_still_busy", busy, 1);
    @(negedge clk);
    check("lit_tmo_idle", busy, 0);
    send_byte(8'h06);
    @(negedge clk);
    check("lit_tmo_then_hold", cpu_hold, 1);

    // Gap of exactly TIMEOUT_CYC idle cycles is still accepted
    send_byte(8'h07);
    send_byte(8'h02); send_byte(8'h34);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h56);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h78);
    @(negedge clk);
    check("lit_gap_we", bus_if.bus_we, 1);
    check("lit_gap_addr", bus_if.bus_addr, 16'h3456);
    check("lit_gap_data", bus_if.bus_wdata, 8'h78);

    // One idle cycle more aborts; the next byte is a command
    send_byte(8'h02); send_byte(8'h9A);
    idle(TIMEOUT_CYC);
    send_byte(8'h06);
    @(negedge clk);
    check("lit_gap_over_hold", cpu_hold, 1);
    check("lit_gap_over_busy", busy, 0);
    send_byte(8'h07);

    // Read with transmitter busy; extra bytes ignored
    ext_busy  = 1'b1;
    rdata_val = 8'h81;
    send_byte(8'h03); send_byte(8'h44); send_byte(8'h55);
    send_byte(8'h02); send_byte(8'h06); send_byte(8'h03);
    idle(38);
    check("lit_txbusy_no_start", tx_start, 0);
    #1 ext_busy = 1'b0;
    @(negedge clk);
    check("lit_txbusy_start", tx_start, 1);
    check("lit_txbusy_data", tx_data, 8'h81);
    check("lit_txbusy_hold", cpu_hold, 0);
    wait_idle(20);

    // Reset during a read
    send_byte(8'h06);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    check("lit_rst_re", bus_if.bus_re, 0);
    check("lit_rst_busy", busy, 0);
    check("lit_rst_hold", cpu_hold, 0);
    check("lit_rst_addr", bus_if.bus_addr, 0);
    check("lit_rst_txdata", tx_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF);
    @(negedge clk);
    check("lit_post_rst_we", bus_if.bus_we, 1);
    check("lit_post_rst_addr", bus_if.bus_addr, 16'h0000);
    check("lit_post_rst_data", bus_if.bus_wdata, 8'hFF);

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
